// File: rtl/mem_access_stage.sv
// Data-memory access stage of the RV32I pipeline: turns EX/MEM load/store controls into a
// req/ready bus transaction, builds byte enables and store lanes, and formats load data.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic [31:0] DataMemOutW,
    output logic        StallMem,
    output logic        MisalignW,
    output logic        AccessFaultW
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] data_q, data_d;
    logic        mis_q, mis_d;
    logic        flt_q, flt_d;

    logic        access, is_store, legal, aligned;
    logic [3:0]  be_new;
    logic [31:0] wdata_new, load_fmt;
    logic [7:0]  lbyte;
    logic [15:0] lhalf;

    // Request decode from the EX/MEM controls; a simultaneous read+write is a store.
    always_comb begin
        access   = MemReadM | MemWriteM;
        is_store = MemWriteM;
        if (is_store) begin
            legal = Funct3M inside {3'b000, 3'b001, 3'b010};
        end else begin
            legal = Funct3M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end
        case (Funct3M[1:0])
            2'b01:   aligned = ~ALUOutM[0];
            2'b10:   aligned = (ALUOutM[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        be_new    = 4'b1111;
        wdata_new = 32'h0;
        if (is_store) begin
            case (Funct3M[1:0])
                2'b00: begin
                    be_new    = 4'b0001 << ALUOutM[1:0];
                    wdata_new = {4{WriteDataM[7:0]}};
                end
                2'b01: begin
                    be_new    = ALUOutM[1] ? 4'b1100 : 4'b0011;
                    wdata_new = {2{WriteDataM[15:0]}};
                end
                default: begin
                    be_new    = 4'b1111;
                    wdata_new = WriteDataM;
                end
            endcase
        end
    end

    // Load formatting uses the registered funct3/offset since the bus data arrives in BUSY.
    always_comb begin
        case (off_q)
            2'd0:    lbyte = dmem_rdata[7:0];
            2'd1:    lbyte = dmem_rdata[15:8];
            2'd2:    lbyte = dmem_rdata[23:16];
            default: lbyte = dmem_rdata[31:24];
        endcase
        lhalf = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_fmt = {{24{lbyte[7]}}, lbyte};
            3'b001:  load_fmt = {{16{lhalf[15]}}, lhalf};
            3'b100:  load_fmt = {24'h0, lbyte};
            3'b101:  load_fmt = {16'h0, lhalf};
            default: load_fmt = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        data_d   = data_q;
        mis_d    = 1'b0;
        flt_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (access) begin
                    if (legal && aligned) begin
                        req_d    = 1'b1;
                        we_d     = is_store;
                        addr_d   = {ALUOutM[31:2], 2'b00};
                        be_d     = be_new;
                        wdata_d  = wdata_new;
                        funct3_d = Funct3M;
                        off_d    = ALUOutM[1:0];
                        cnt_d    = 8'd0;
                        state_d  = StBusy;
                    end else begin
                        data_d  = 32'h0;
                        mis_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StBusy: begin
                // Ready wins over timeout when both land in the same cycle.
                if (dmem_ready) begin
                    req_d   = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = StDone;
                    if (!we_q) begin
                        data_d = load_fmt;
                    end
                end else if (cnt_q == CntLast) begin
                    req_d   = 1'b0;
                    cnt_d   = 8'd0;
                    data_d  = 32'h0;
                    flt_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            be_q     <= 4'h0;
            funct3_q <= 3'b000;
            off_q    <= 2'b00;
            data_q   <= 32'h0;
            mis_q    <= 1'b0;
            flt_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            data_q   <= data_d;
            mis_q    <= mis_d;
            flt_q    <= flt_d;
        end
    end

    // Stall is combinational in IDLE so the hazard unit freezes in the same cycle.
    assign StallMem     = ~reset & ((state_q == StBusy) | ((state_q == StIdle) & access));
    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign dmem_be      = be_q;
    assign DataMemOutW  = data_q;
    assign MisalignW    = mis_q;
    assign AccessFaultW = flt_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed-vector bench for mem_access_stage: a table of load/store transactions plus
// hand-written sequences for reset mid-access and back-to-back accesses.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUOutM, WriteDataM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic [31:0] DataMemOutW;
    logic        StallMem, MisalignW, AccessFaultW;

    int n_vec = 0;
    int n_err = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .MemReadM     (MemReadM),
        .MemWriteM    (MemWriteM),
        .Funct3M      (Funct3M),
        .ALUOutM      (ALUOutM),
        .WriteDataM   (WriteDataM),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_be      (dmem_be),
        .dmem_rdata   (dmem_rdata),
        .dmem_ready   (dmem_ready),
        .DataMemOutW  (DataMemOutW),
        .StallMem     (StallMem),
        .MisalignW    (MisalignW),
        .AccessFaultW (AccessFaultW)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          delay;      // BUSY cycle index in which ready rises; -1 = never
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
        logic        exp_mis;
        logic        exp_flt;
        int          exp_req;    // cycles with dmem_req high
        int          exp_stall;  // cycles with StallMem high
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
            n_err++;
        end
    endtask

    task automatic drive_idle();
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        Funct3M    = 3'b000;
        ALUOutM    = 32'h0;
        WriteDataM = 32'h0;
        dmem_rdata = 32'h0;
        dmem_ready = 1'b0;
    endtask

    // Called just after a falling edge with the DUT idle; returns just after a falling edge.
    task automatic apply(input int idx, input vec_t v);
        int  stall_n = 0;
        int  req_n   = 0;
        bit  done    = 0;
        string tag;
        tag = $sformatf("v%0d", idx);
        MemReadM   = v.rd;
        MemWriteM  = v.wr;
        Funct3M    = v.f3;
        ALUOutM    = v.addr;
        WriteDataM = v.wd;
        dmem_rdata = v.rdata;
        dmem_ready = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (StallMem) begin
                stall_n++;
                if (dmem_req) begin
                    chk({tag, " addr"}, dmem_addr, v.exp_addr);
                    chk({tag, " be"}, {28'h0, dmem_be}, {28'h0, v.exp_be});
                    chk({tag, " we"}, {31'h0, dmem_we}, {31'h0, v.exp_we});
                    if (v.wr) chk({tag, " wdata"}, dmem_wdata, v.exp_wdata);
                    dmem_ready = (req_n == v.delay);
                    req_n++;
                end
                @(negedge clk);
            end else begin
                done = 1;
            end
        end
        chk({tag, " completed"}, {31'h0, done}, 32'h1);
        chk({tag, " req cycles"}, req_n, v.exp_req);
        chk({tag, " stall cycles"}, stall_n, v.exp_stall);
        chk({tag, " done req"}, {31'h0, dmem_req}, 32'h0);
        chk({tag, " data"}, DataMemOutW, v.exp_data);
        chk({tag, " misalign"}, {31'h0, MisalignW}, {31'h0, v.exp_mis});
        chk({tag, " fault"}, {31'h0, AccessFaultW}, {31'h0, v.exp_flt});
        drive_idle();
        @(negedge clk);
        #1;
        chk({tag, " post misalign"}, {31'h0, MisalignW}, 32'h0);
        chk({tag, " post fault"}, {31'h0, AccessFaultW}, 32'h0);
        chk({tag, " post stall"}, {31'h0, StallMem}, 32'h0);
        chk({tag, " post data"}, DataMemOutW, v.exp_data);
        n_vec++;
    endtask

    initial begin
        //            rd wr f3      addr          wd            rdata       dly
        //            exp_addr      be     we wdata          data         mis flt req stall
        vecs[0]  = '{1, 0, 3'b000, 32'h1003, 32'h0, 32'h80FF_1234, 0,
                     32'h1000, 4'hF, 0, 32'h0, 32'hFFFF_FF80, 0, 0, 1, 2};
        vecs[1]  = '{1, 0, 3'b100, 32'h1003, 32'h0, 32'h80FF_1234, 0,
                     32'h1000, 4'hF, 0, 32'h0, 32'h0000_0080, 0, 0, 1, 2};
        vecs[2]  = '{0, 1, 3'b001, 32'h2002, 32'hDEAD_BEEF, 32'h0, 3,
                     32'h2000, 4'hC, 1, 32'hBEEF_BEEF, 32'h0000_0080, 0, 0, 4, 5};
        vecs[3]  = '{1, 0, 3'b010, 32'h3001, 32'h0, 32'h0, 0,
                     32'h0, 4'h0, 0, 32'h0, 32'h0, 1, 0, 0, 1};
        vecs[4]  = '{1, 0, 3'b011, 32'h3000, 32'h0, 32'h0, 0,
                     32'h0, 4'h0, 0, 32'h0, 32'h0, 1, 0, 0, 1};
        vecs[5]  = '{1, 0, 3'b010, 32'h40, 32'h0, 32'h1234_5678, 1,
                     32'h40, 4'hF, 0, 32'h0, 32'h1234_5678, 0, 0, 2, 3};
        vecs[6]  = '{1, 0, 3'b010, 32'h50, 32'h0, 32'hFFFF_FFFF, -1,
                     32'h50, 4'hF, 0, 32'h0, 32'h0, 0, 1, 4, 5};
        vecs[7]  = '{1, 0, 3'b001, 32'h62, 32'h0, 32'h8001_7FFF, 0,
                     32'h60, 4'hF, 0, 32'h0, 32'hFFFF_8001, 0, 0, 1, 2};
        vecs[8]  = '{1, 0, 3'b101, 32'h60, 32'h0, 32'h8001_F00D, 0,
                     32'h60, 4'hF, 0, 32'h0, 32'h0000_F00D, 0, 0, 1, 2};
        vecs[9]  = '{0, 1, 3'b000, 32'h71, 32'h0000_00A5, 32'h0, 0,
                     32'h70, 4'h2, 1, 32'hA5A5_A5A5, 32'h0000_F00D, 0, 0, 1, 2};
        vecs[10] = '{0, 1, 3'b010, 32'h80, 32'hCAFE_BABE, 32'h0, 2,
                     32'h80, 4'hF, 1, 32'hCAFE_BABE, 32'h0000_F00D, 0, 0, 3, 4};
        vecs[11] = '{0, 1, 3'b011, 32'h90, 32'h1, 32'h0, 0,
                     32'h0, 4'h0, 0, 32'h0, 32'h0, 1, 0, 0, 1};
        vecs[12] = '{1, 1, 3'b010, 32'hA0, 32'h0102_0304, 32'hFFFF_FFFF, 0,
                     32'hA0, 4'hF, 1, 32'h0102_0304, 32'h0, 0, 0, 1, 2};
        vecs[13] = '{1, 0, 3'b000, 32'hB1, 32'h0, 32'h0000_7F00, 0,
                     32'hB0, 4'hF, 0, 32'h0, 32'h0000_007F, 0, 0, 1, 2};
        vecs[14] = '{0, 1, 3'b001, 32'hA1, 32'h1234, 32'h0, 0,
                     32'h0, 4'h0, 0, 32'h0, 32'h0, 1, 0, 0, 1};
        vecs[15] = '{1, 0, 3'b100, 32'hB2, 32'h0, 32'h00AB_0000, 0,
                     32'hB0, 4'hF, 0, 32'h0, 32'h0000_00AB, 0, 0, 1, 2};
        vecs[16] = '{0, 1, 3'b000, 32'hC3, 32'h0000_0011, 32'h0, -1,
                     32'hC0, 4'h8, 1, 32'h1111_1111, 32'h0, 0, 1, 4, 5};
        vecs[17] = '{0, 1, 3'b001, 32'hD0, 32'h0000_1234, 32'h0, 0,
                     32'hD0, 4'h3, 1, 32'h1234_1234, 32'h0, 0, 0, 1, 2};

        reset = 1'b1;
        drive_idle();
        repeat (3) @(negedge clk);
        #1;
        chk("reset req", {31'h0, dmem_req}, 32'h0);
        chk("reset we", {31'h0, dmem_we}, 32'h0);
        chk("reset addr", dmem_addr, 32'h0);
        chk("reset wdata", dmem_wdata, 32'h0);
        chk("reset be", {28'h0, dmem_be}, 32'h0);
        chk("reset data", DataMemOutW, 32'h0);
        chk("reset stall", {31'h0, StallMem}, 32'h0);
        chk("reset misalign", {31'h0, MisalignW}, 32'h0);
        chk("reset fault", {31'h0, AccessFaultW}, 32'h0);
        n_vec++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 18; i++) apply(i, vecs[i]);

        // Back-to-back: LW 0x10 then SW 0x14; ready raised in DONE/IDLE must be ignored.
        MemReadM   = 1'b1;
        Funct3M    = 3'b010;
        ALUOutM    = 32'h10;
        dmem_rdata = 32'h1111_1111;
        @(negedge clk);
        #1;
        chk("b2b lw req", {31'h0, dmem_req}, 32'h1);
        dmem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("b2b lw done stall", {31'h0, StallMem}, 32'h0);
        chk("b2b lw data", DataMemOutW, 32'h1111_1111);
        MemReadM   = 1'b0;
        MemWriteM  = 1'b1;
        ALUOutM    = 32'h14;
        WriteDataM = 32'h2222_3333;
        @(negedge clk);
        #1;
        chk("b2b sw idle stall", {31'h0, StallMem}, 32'h1);
        chk("b2b sw idle req", {31'h0, dmem_req}, 32'h0);
        chk("b2b data held", DataMemOutW, 32'h1111_1111);
        dmem_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("b2b sw req", {31'h0, dmem_req}, 32'h1);
        chk("b2b sw addr", dmem_addr, 32'h14);
        chk("b2b sw we", {31'h0, dmem_we}, 32'h1);
        chk("b2b sw wdata", dmem_wdata, 32'h2222_3333);
        dmem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("b2b sw done stall", {31'h0, StallMem}, 32'h0);
        chk("b2b sw data kept", DataMemOutW, 32'h1111_1111);
        drive_idle();
        @(negedge clk);
        n_vec++;

        // Reset while BUSY: request must drop at once and nothing may fire afterwards.
        MemReadM = 1'b1;
        Funct3M  = 3'b010;
        ALUOutM  = 32'h200;
        @(negedge clk);
        #1;
        chk("rst busy req", {31'h0, dmem_req}, 32'h1);
        reset = 1'b1;
        #1;
        chk("rst req drop", {31'h0, dmem_req}, 32'h0);
        chk("rst stall", {31'h0, StallMem}, 32'h0);
        drive_idle();
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            chk("rst after req", {31'h0, dmem_req}, 32'h0);
            chk("rst after stall", {31'h0, StallMem}, 32'h0);
            chk("rst after misalign", {31'h0, MisalignW}, 32'h0);
            chk("rst after fault", {31'h0, AccessFaultW}, 32'h0);
        end
        n_vec++;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
